// File: rtl/riscv_store_monitor.sv
// riscv_store_monitor
//   Self-check monitor for RV32I pipeline test programs. Watches the
//   data-memory store bus and compares each store against NUM_CHK
//   programmable address/expected-data channels, then reports PASS,
//   FAIL (with the failing channel and data) or TIMEOUT, plus a RUN
//   cycle count.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse: arm monitor, clear results, enter RUN
//   chk_en     in   per-channel enable, captured on start
//   chk_addr   in   packed check addresses, ch i at [i*ADDR_W +: ADDR_W]
//   chk_data   in   packed expected data, same packing
//   memwrite   in   store strobe from the pipeline
//   dataadr    in   store address
//   writedata  in   store data
//   state      out  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
//   done       out  high in PASS/FAIL/TIMEOUT
//   pass       out  high only in PASS
//   hit_mask   out  channels that received a correct store
//   fail_chan  out  lowest channel index of the first mismatch
//   fail_data  out  writedata of the first mismatch
//   cycles     out  RUN cycles elapsed, frozen on exit from RUN
module riscv_store_monitor #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int NUM_CHK     = 4,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 300,
   parameter int STOP_ON_ERR = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NUM_CHK-1:0]        chk_en,
   input  logic [NUM_CHK*ADDR_W-1:0] chk_addr,
   input  logic [NUM_CHK*DATA_W-1:0] chk_data,
   input  logic                      memwrite,
   input  logic [ADDR_W-1:0]         dataadr,
   input  logic [DATA_W-1:0]         writedata,
   output logic [2:0]                state,
   output logic                      done,
   output logic                      pass,
   output logic [NUM_CHK-1:0]        hit_mask,
   output logic [3:0]                fail_chan,
   output logic [DATA_W-1:0]         fail_data,
   output logic [CNT_W-1:0]          cycles
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RUN     = 3'd1;
   localparam logic [2:0] ST_PASS    = 3'd2;
   localparam logic [2:0] ST_FAIL    = 3'd3;
   localparam logic [2:0] ST_TIMEOUT = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic             STOP_EN  = (STOP_ON_ERR != 0);

   // shadow copies of the channel programming, frozen at start
   logic [NUM_CHK-1:0]        en_r;
   logic [NUM_CHK*ADDR_W-1:0] addr_r;
   logic [NUM_CHK*DATA_W-1:0] data_r;
   // channels that have seen at least one mismatching store, and any-error flag
   logic [NUM_CHK-1:0]        errch_r;
   logic                      err_r;

   logic                      run_store_s;
   logic [NUM_CHK-1:0]        hit_set_s;
   logic [NUM_CHK-1:0]        err_set_s;
   logic [3:0]                first_chan_s;
   logic [NUM_CHK-1:0]        nxt_hit_s;
   logic [NUM_CHK-1:0]        nxt_errch_s;
   logic                      nxt_err_s;
   logic                      all_written_s;
   logic                      all_hit_s;
   logic [CNT_W-1:0]          cyc_inc_s;
   logic [2:0]                next_state_s;

   assign run_store_s = memwrite && (state == ST_RUN);

   // Per-channel address match and data compare; descending scan so the lowest mismatching index wins
   always_comb begin
      hit_set_s    = '0;
      err_set_s    = '0;
      first_chan_s = 4'd0;
      for (int i = NUM_CHK - 1; i >= 0; i--) begin
         if (run_store_s && en_r[i] && (dataadr == addr_r[i*ADDR_W +: ADDR_W])) begin
            if (writedata == data_r[i*DATA_W +: DATA_W]) begin
               hit_set_s[i] = 1'b1;
            end else begin
               err_set_s[i] = 1'b1;
               first_chan_s = 4'(i);
            end
         end else begin
            hit_set_s[i] = 1'b0;
         end
      end
   end

   // Exit decision from RUN, evaluated on the post-store hit/error view
   always_comb begin
      nxt_hit_s     = hit_mask | hit_set_s;
      nxt_errch_s   = errch_r | err_set_s;
      nxt_err_s     = err_r | (|err_set_s);
      // a channel counts as written once it has seen any store, correct or not
      all_written_s = (((nxt_hit_s | nxt_errch_s) & en_r) == en_r);
      all_hit_s     = ((nxt_hit_s & en_r) == en_r);
      if (cycles == CNT_MAX) begin
         cyc_inc_s = cycles;
      end else begin
         cyc_inc_s = cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (nxt_err_s && STOP_EN) begin
         next_state_s = ST_FAIL;
      end else if (all_written_s && nxt_err_s) begin
         next_state_s = ST_FAIL;
      end else if (all_hit_s) begin
         next_state_s = ST_PASS;
      end else if (cycles == CNT_LAST) begin
         next_state_s = ST_TIMEOUT;
      end else begin
         next_state_s = ST_RUN;
      end
   end

   // Monitor state, shadow registers and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_r      <= '0;
         addr_r    <= '0;
         data_r    <= '0;
         errch_r   <= '0;
         err_r     <= 1'b0;
         state     <= ST_IDLE;
         done      <= 1'b0;
         pass      <= 1'b0;
         hit_mask  <= '0;
         fail_chan <= 4'd0;
         fail_data <= '0;
         cycles    <= '0;
      end else if (start && (state != ST_RUN)) begin
         en_r      <= chk_en;
         addr_r    <= chk_addr;
         data_r    <= chk_data;
         errch_r   <= '0;
         err_r     <= 1'b0;
         state     <= ST_RUN;
         done      <= 1'b0;
         pass      <= 1'b0;
         hit_mask  <= '0;
         fail_chan <= 4'd0;
         fail_data <= '0;
         cycles    <= '0;
      end else if (state == ST_RUN) begin
         hit_mask <= nxt_hit_s;
         errch_r  <= nxt_errch_s;
         err_r    <= nxt_err_s;
         cycles   <= cyc_inc_s;
         // only the first erroneous store is recorded
         if (!err_r && (|err_set_s)) begin
            fail_chan <= first_chan_s;
            fail_data <= writedata;
         end
         state <= next_state_s;
         done  <= (next_state_s != ST_RUN);
         pass  <= (next_state_s == ST_PASS);
      end else if (state > ST_TIMEOUT) begin
         // illegal encoding recovers to IDLE
         state <= ST_IDLE;
         done  <= 1'b0;
         pass  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_store_monitor.sv
module tb_riscv_store_monitor;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [3:0]   chk_en;
   logic [127:0] chk_addr;
   logic [127:0] chk_data;
   logic         memwrite;
   logic [31:0]  dataadr;
   logic [31:0]  writedata;

   logic [2:0]   state,     state_ne;
   logic         done,      done_ne;
   logic         pass,      pass_ne;
   logic [3:0]   hit_mask,  hit_mask_ne;
   logic [3:0]   fail_chan, fail_chan_ne;
   logic [31:0]  fail_data, fail_data_ne;
   logic [15:0]  cycles,    cycles_ne;

   int n_checks;
   int n_pass;

   riscv_store_monitor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .chk_en(chk_en),
      .chk_addr(chk_addr), .chk_data(chk_data), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .state(state), .done(done),
      .pass(pass), .hit_mask(hit_mask), .fail_chan(fail_chan),
      .fail_data(fail_data), .cycles(cycles)
   );

   riscv_store_monitor #(.STOP_ON_ERR(0)) dut_ne (
      .clk(clk), .rst_n(rst_n), .start(start), .chk_en(chk_en),
      .chk_addr(chk_addr), .chk_data(chk_data), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .state(state_ne), .done(done_ne),
      .pass(pass_ne), .hit_mask(hit_mask_ne), .fail_chan(fail_chan_ne),
      .fail_data(fail_data_ne), .cycles(cycles_ne)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic program_ch(input int ch, input logic [31:0] a, input logic [31:0] d);
      chk_addr[ch*32 +: 32] = a;
      chk_data[ch*32 +: 32] = d;
   endtask

   task automatic do_start(input logic [3:0] en);
      chk_en = en;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      tick();
      memwrite  = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      chk_en    = 4'd0;
      chk_addr  = 128'd0;
      chk_data  = 128'd0;
      memwrite  = 1'b0;
      dataadr   = 32'd0;
      writedata = 32'd0;
      ticks(3);
      check("rst_state", state, 3'd0);
      check("rst_done", done, 1'b0);
      check("rst_cycles", cycles, 16'd0);
      rst_n = 1'b1;
      tick();

      // 1: pass at RUN cycle 40, with a start pulse mid-RUN that must be ignored
      program_ch(0, 32'd500, 32'd18);
      do_start(4'b0001);
      check("t1_run", state, 3'd1);
      check("t1_cyc0", cycles, 16'd0);
      ticks(20);
      chk_en = 4'b0000;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      ticks(19);
      check("t1_cyc40", cycles, 16'd40);
      check("t1_still_run", state, 3'd1);
      store(32'd500, 32'd18);
      check("t1_state", state, 3'd2);
      check("t1_pass", pass, 1'b1);
      check("t1_done", done, 1'b1);
      check("t1_hit", hit_mask, 4'b0001);
      check("t1_cycles", cycles, 16'd41);
      ticks(3);
      check("t1_frozen", cycles, 16'd41);

      // 2: wrong data; restart after PASS clears hit_mask and cycles
      do_start(4'b0001);
      check("t2_rearm_hit", hit_mask, 4'b0000);
      check("t2_rearm_cyc", cycles, 16'd0);
      store(32'd500, 32'd17);
      check("t2_state", state, 3'd3);
      check("t2_chan", fail_chan, 4'd0);
      check("t2_data", fail_data, 32'd17);
      check("t2_pass", pass, 1'b0);
      check("t2_ne_state", state_ne, 3'd3);

      // 3: STOP_ON_ERR=0 keeps running until all channels written
      program_ch(0, 32'd100, 32'd5);
      program_ch(1, 32'd104, 32'd7);
      do_start(4'b0011);
      store(32'd100, 32'd6);
      check("t3_ne_run", state_ne, 3'd1);
      check("t3_stop_fail", state, 3'd3);
      store(32'd104, 32'd7);
      check("t3_ne_state", state_ne, 3'd3);
      check("t3_ne_chan", fail_chan_ne, 4'd0);
      check("t3_ne_data", fail_data_ne, 32'd6);
      check("t3_ne_hit", hit_mask_ne, 4'b0010);

      // 4: timeout, then completing store on the last cycle wins
      program_ch(0, 32'd500, 32'd18);
      do_start(4'b0001);
      ticks(299);
      check("t4_pre_run", state, 3'd1);
      check("t4_pre_cyc", cycles, 16'd299);
      tick();
      check("t4_timeout", state, 3'd4);
      check("t4_cycles", cycles, 16'd300);
      check("t4_done", done, 1'b1);
      store(32'd500, 32'd18);
      check("t4_ignored_hit", hit_mask, 4'b0000);
      check("t4_hold", state, 3'd4);
      do_start(4'b0001);
      ticks(299);
      store(32'd500, 32'd18);
      check("t4_late_pass", state, 3'd2);
      check("t4_late_cyc", cycles, 16'd300);

      // 5: two channels on one address, lowest mismatching channel reported
      program_ch(1, 32'd200, 32'd3);
      program_ch(2, 32'd200, 32'd4);
      do_start(4'b0110);
      store(32'd300, 32'd3);
      check("t5_nomatch", state, 3'd1);
      store(32'd200, 32'd3);
      check("t5_state", state, 3'd3);
      check("t5_chan", fail_chan, 4'd2);
      check("t5_data", fail_data, 32'd3);
      check("t5_hit", hit_mask, 4'b0010);

      // all channels disabled: PASS after one RUN cycle
      do_start(4'b0000);
      tick();
      check("t_none_state", state, 3'd2);
      check("t_none_cyc", cycles, 16'd1);

      // 6: asynchronous reset mid-RUN, stores in IDLE ignored
      program_ch(0, 32'd500, 32'd18);
      do_start(4'b0001);
      ticks(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_state", state, 3'd0);
      check("t6_cycles", cycles, 16'd0);
      check("t6_done", done, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      store(32'd500, 32'd18);
      check("t6_idle_state", state, 3'd0);
      check("t6_idle_hit", hit_mask, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
